instruction_fetch: RTL

Instruction fetch stage placed directly upstream of the instruction cache and feeding the decode stage. Holds the program counter, drives the cache word pointer, and captures each returned instruction on the cache's success pulse into a small FIFO. Decode pops the FIFO with a valid/ready handshake. A redirect input from execute retargets fetch and flushes in-flight state.

---
 rtl/instruction_fetch_if.sv | 23 ++
 rtl/instruction_fetch.sv | 100 ++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: cache word port, redirect input and decode handshake.
// master = fetch stage, slave = cache/decode/execute side.
interface instruction_fetch_if;
   logic [31:0] fetchPtr;
   logic [31:0] fetchData;
   logic        fetchSuccess;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        instValid;
   logic [31:0] instData;
   logic [31:0] instPc;
   logic        instReady;

   modport master (
      output fetchPtr, instValid, instData, instPc,
      input  fetchData, fetchSuccess, redirect, redirectPc, instReady
   );

   modport slave (
      input  fetchPtr, instValid, instData, instPc,
      output fetchData, fetchSuccess, redirect, redirectPc, instReady
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, cache word pointer and instruction FIFO.
// Redirects flush the FIFO and drop the response that follows.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 4,
   localparam int         AW          = $clog2(QUEUE_DEPTH),
   localparam int         CW          = AW + 1
) (
   input  logic                clk,
   input  logic                reset,
   instruction_fetch_if.master bus,
   output logic [CW-1:0]       queueCount
);

   localparam logic [1:0] FETCH  = 2'd0;
   localparam logic [1:0] HOLD   = 2'd1;
   localparam logic [1:0] SETTLE = 2'd2;

   localparam logic [31:0]   PC_INIT = {RESET_PC[31:2], 2'b00};
   localparam logic [CW-1:0] FULL    = CW'(QUEUE_DEPTH);

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [31:0]   pc;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          valid;
   logic          push;
   logic          pop;

   logic [31:0] mem_data [QUEUE_DEPTH];
   logic [31:0] mem_pc   [QUEUE_DEPTH];

   assign valid = (count != '0);
   assign push  = (state == FETCH) && bus.fetchSuccess && !bus.redirect;
   assign pop   = valid && bus.instReady && !bus.redirect;

   assign bus.fetchPtr  = {2'b00, pc[31:2]};
   assign bus.instValid = valid;
   assign bus.instData  = valid ? mem_data[head] : '0;
   assign bus.instPc    = valid ? mem_pc[head] : '0;
   assign queueCount    = count;

   // occupancy after this edge, ignoring redirect flush
   always_comb begin
      count_nxt = count;
      unique case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // fetch control: stall when full, skip one response after a redirect
   always_comb begin
      state_nxt = state;
      unique case (state)
         FETCH: if (push && count_nxt == FULL) state_nxt = HOLD;
         HOLD:  if (pop) state_nxt = FETCH;
         SETTLE: state_nxt = FETCH;
         default: state_nxt = FETCH;
      endcase
   end

   // pc, FIFO pointers and state; redirect beats push and pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         pc    <= PC_INIT;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (bus.redirect) begin
         state <= SETTLE;
         pc    <= {bus.redirectPc[31:2], 2'b00};
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (push) begin
            pc   <= pc + 32'd4;
            tail <= tail + AW'(1);
         end
         if (pop) head <= head + AW'(1);
      end
   end

   // FIFO storage; contents are only visible while counted valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[tail] <= bus.fetchData;
         mem_pc[tail]   <= pc;
      end
   end

endmodule
